// File: rtl/debounced_event_counter.sv
// Multi-channel switch event counter: per-channel synchroniser, debouncer, raw and debounced
// edge counters, plus a four-digit 7-segment view of one selected channel.
module debounced_event_counter #(
  parameter int N_CH      = 4,
  parameter int CNT_W     = 8,
  parameter int DB_CYCLES = 500000,
  parameter int SATURATE  = 0,
  parameter int SEL_W     = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         SW,
  input  logic                    clr,
  input  logic [1:0]              edge_mode,
  input  logic [SEL_W-1:0]        sel,
  output logic [N_CH*CNT_W-1:0]   cnt,
  output logic [N_CH*CNT_W-1:0]   cnt_raw,
  output logic [N_CH-1:0]         ovf,
  output logic [N_CH-1:0]         db_pulse,
  output logic [6:0]              HEX5,
  output logic [6:0]              HEX4,
  output logic [6:0]              HEX1,
  output logic [6:0]              HEX0
);

  localparam int                TMR_W    = $clog2(DB_CYCLES);
  localparam logic [TMR_W-1:0]  DB_LAST  = TMR_W'(DB_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TMR_ONE  = TMR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [6:0]        SEG_DASH = 7'b0111111;

  function automatic logic qualify(input logic [1:0] mode, input logic from_lvl, input logic to_lvl);
    logic q;
    case (mode)
      2'b00:   q = ~from_lvl & to_lvl;
      2'b01:   q = from_lvl & ~to_lvl;
      2'b10:   q = from_lvl ^ to_lvl;
      default: q = 1'b0;
    endcase
    return q;
  endfunction

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;  4'h1: s = 7'b1111001;  4'h2: s = 7'b0100100;  4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;  4'h5: s = 7'b0010010;  4'h6: s = 7'b0000010;  4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;  4'h9: s = 7'b0010000;  4'hA: s = 7'b0001000;  4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;  4'hD: s = 7'b0100001;  4'hE: s = 7'b0000110;  4'hF: s = 7'b0001110;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  logic [N_CH*8-1:0] cnt8_all;
  logic [N_CH*8-1:0] raw8_all;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic             s1, s2, stable, hit, ovf_q, pulse_q;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] cnt_q, raw_q;
    logic             raw_inc, db_done, db_inc;

    assign raw_inc = qualify(edge_mode, s2, s1);
    assign db_done = (s2 != stable) && (timer == DB_LAST);
    assign db_inc  = db_done && qualify(edge_mode, stable, s2);

    // Sync, debounce and count; clr beats any same-cycle increment and suppresses its pulse.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
        s1      <= 1'b0;
        s2      <= 1'b0;
        stable  <= 1'b0;
        timer   <= {TMR_W{1'b0}};
        cnt_q   <= {CNT_W{1'b0}};
        raw_q   <= {CNT_W{1'b0}};
        ovf_q   <= 1'b0;
        hit     <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        s1 <= SW[i];
        s2 <= s1;
        if (s2 == stable) begin
          timer <= {TMR_W{1'b0}};
        end else if (db_done) begin
          timer  <= {TMR_W{1'b0}};
          stable <= s2;
        end else begin
          timer <= timer + TMR_ONE;
        end
        if (clr) begin
          cnt_q <= {CNT_W{1'b0}};
          raw_q <= {CNT_W{1'b0}};
          ovf_q <= 1'b0;
        end else begin
          if (raw_inc) raw_q <= raw_q + CNT_ONE;
          if (db_inc) begin
            if (cnt_q == CNT_MAX) begin
              ovf_q <= 1'b1;
              if (SATURATE == 0) cnt_q <= {CNT_W{1'b0}};
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        hit     <= db_inc & ~clr;
        pulse_q <= hit;
      end
    end

    assign cnt[i*CNT_W +: CNT_W]     = cnt_q;
    assign cnt_raw[i*CNT_W +: CNT_W] = raw_q;
    assign ovf[i]                    = ovf_q;
    assign db_pulse[i]               = pulse_q;

    if (CNT_W >= 8) begin : g_wide
      assign cnt8_all[i*8 +: 8] = cnt_q[7:0];
      assign raw8_all[i*8 +: 8] = raw_q[7:0];
    end else begin : g_narrow
      assign cnt8_all[i*8 +: 8] = {{(8-CNT_W){1'b0}}, cnt_q};
      assign raw8_all[i*8 +: 8] = {{(8-CNT_W){1'b0}}, raw_q};
    end
  end

  logic [7:0] show_cnt, show_raw;
  logic       sel_ok;

  // Display mux; an out-of-range select blanks every digit to a dash.
  always_comb begin
    show_cnt = 8'h00;
    show_raw = 8'h00;
    sel_ok   = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      show_cnt = (sel == SEL_W'(i)) ? cnt8_all[i*8 +: 8] : show_cnt;
      show_raw = (sel == SEL_W'(i)) ? raw8_all[i*8 +: 8] : show_raw;
      sel_ok   = sel_ok | (sel == SEL_W'(i));
    end
    if (sel_ok) begin
      HEX5 = hex7(show_cnt[7:4]);
      HEX4 = hex7(show_cnt[3:0]);
      HEX1 = hex7(show_raw[7:4]);
      HEX0 = hex7(show_raw[3:0]);
    end else begin
      HEX5 = SEG_DASH;
      HEX4 = SEG_DASH;
      HEX1 = SEG_DASH;
      HEX0 = SEG_DASH;
    end
  end

endmodule
